// File: rtl/clint_multi.sv
// -----------------------------------------------------------------------------
// clint_multi
// Core-local interruptor for the multicore CPU. It holds one shared 64-bit
// mtime and, for each hart, a 64-bit mtimecmp and a 1-bit msip. It drives one
// timer and one software interrupt line to each hart.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   req_valid/we/addr  register bus request, accepted every cycle
//   req_wdata          32-bit write data (full word only)
//   rsp_valid          response strobe, one cycle after each request
//   rsp_rdata          registered read data (0 for writes and errors)
//   rsp_err            unmapped, misaligned or out-of-range hart access
//   timer_irq[h]       mtime >= mtimecmp[h]
//   soft_irq[h]        msip[h]
//   mtime_out          current mtime, for debug and trace
// -----------------------------------------------------------------------------
module clint_multi #(
  parameter int NUM_HARTS = 2,
  parameter int PRESCALE  = 1,
  parameter int ADDR_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_HARTS-1:0] timer_irq,
  output logic [NUM_HARTS-1:0] soft_irq,
  output logic [63:0]          mtime_out
);

  localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX   = PS_W'(PRESCALE - 1);
  localparam logic [4:0]      NH       = 5'(NUM_HARTS);
  localparam logic [ADDR_W-1:0] CMP_BASE = ADDR_W'(32'h4000);
  localparam logic [ADDR_W-1:0] MTIME_LO = ADDR_W'(32'hBFF8);
  localparam logic [ADDR_W-1:0] MTIME_HI = ADDR_W'(32'hBFFC);

  logic [PS_W-1:0]      cnt_q, cnt_d;
  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          cmp_q [NUM_HARTS];
  logic [63:0]          cmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;

  logic       aligned, msip_hit, cmp_hit, mt_lo_hit, mt_hi_hit, hit;
  logic [3:0] msip_idx, cmp_idx;
  logic       cmp_upper;
  logic       tick, wr;
  logic [31:0] rd_val;

  // Address decode. msip occupies 0x0000..0x003F (4 bytes per hart) and
  // mtimecmp occupies 0x4000..0x407F (8 bytes per hart); hart slots at or
  // beyond NUM_HARTS decode as errors.
  always_comb begin
    aligned   = (req_addr[1:0] == 2'b00);
    msip_idx  = req_addr[5:2];
    cmp_idx   = req_addr[6:3];
    cmp_upper = req_addr[2];
    msip_hit  = aligned && ((req_addr >> 6) == '0) && ({1'b0, msip_idx} < NH);
    cmp_hit   = aligned && ((req_addr >> 7) == (CMP_BASE >> 7)) && ({1'b0, cmp_idx} < NH);
    mt_lo_hit = (req_addr == MTIME_LO);
    mt_hi_hit = (req_addr == MTIME_HI);
    hit       = msip_hit || cmp_hit || mt_lo_hit || mt_hi_hit;
  end

  // Read mux: always the pre-edge register contents.
  always_comb begin
    rd_val = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (msip_hit && msip_idx == 4'(h)) rd_val = {31'b0, msip_q[h]};
      if (cmp_hit && cmp_idx == 4'(h))   rd_val = cmp_upper ? cmp_q[h][63:32] : cmp_q[h][31:0];
    end
    if (mt_lo_hit) rd_val = mtime_q[31:0];
    if (mt_hi_hit) rd_val = mtime_q[63:32];
  end

  // Next-state logic. A software write to either mtime half replaces the
  // increment in that cycle and leaves the other half untouched.
  always_comb begin
    wr    = req_valid && req_we;
    tick  = (cnt_q == PS_MAX);
    cnt_d = tick ? '0 : cnt_q + PS_W'(1);

    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr && mt_lo_hit) mtime_d = {mtime_q[63:32], req_wdata};
    if (wr && mt_hi_hit) mtime_d = {req_wdata, mtime_q[31:0]};

    msip_d = msip_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      cmp_d[h] = cmp_q[h];
      if (wr && msip_hit && msip_idx == 4'(h)) msip_d[h] = req_wdata[0];
      if (wr && cmp_hit && cmp_idx == 4'(h)) begin
        if (cmp_upper) cmp_d[h][63:32] = req_wdata;
        else           cmp_d[h][31:0]  = req_wdata;
      end
    end

    rsp_valid_d = req_valid;
    rsp_err_d   = req_valid && !hit;
    rsp_rdata_d = (req_valid && !req_we && hit) ? rd_val : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mtime_q     <= '0;
      msip_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      for (int h = 0; h < NUM_HARTS; h++) cmp_q[h] <= '1;
    end else begin
      cnt_q       <= cnt_d;
      mtime_q     <= mtime_d;
      msip_q      <= msip_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      for (int h = 0; h < NUM_HARTS; h++) cmp_q[h] <= cmp_d[h];
    end
  end

  // Interrupt levels come straight from registered state.
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) timer_irq[h] = (mtime_q >= cmp_q[h]);
  end

  assign soft_irq  = msip_q;
  assign mtime_out = mtime_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_clint_multi.sv
module tb_clint_multi;

   localparam int NH = 2;
   localparam int P  = 1;

   logic        clock;
   logic        rstN, rstN4;
   logic        reqValid, reqWe;
   logic [15:0] reqAddr;
   logic [31:0] reqWdata;
   logic        rspValid, rspErr;
   logic [31:0] rspRdata;
   logic [1:0]  timerIrq, softIrq;
   logic [63:0] mtimeOut;

   logic        req4Valid, req4We;
   logic [15:0] req4Addr;
   logic [31:0] req4Wdata;
   logic        rsp4Valid, rsp4Err;
   logic [31:0] rsp4Rdata;
   logic [1:0]  timer4Irq, soft4Irq;
   logic [63:0] mtime4Out;

   int checks = 0;
   int errors = 0;

   // Behavioural model state for the PRESCALE=1 instance
   logic [63:0] mTime;
   logic [63:0] mCmp [NH];
   logic        mMsip [NH];
   int          mCyc;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic        expErr;
      logic [31:0] expRdata;
   } vec_t;

   vec_t vecs [16];

   clint_multi #(.NUM_HARTS(NH), .PRESCALE(P), .ADDR_W(16)) uDut (
      .clk(clock), .rst_n(rstN),
      .req_valid(reqValid), .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
      .rsp_valid(rspValid), .rsp_rdata(rspRdata), .rsp_err(rspErr),
      .timer_irq(timerIrq), .soft_irq(softIrq), .mtime_out(mtimeOut)
   );

   clint_multi #(.NUM_HARTS(NH), .PRESCALE(4), .ADDR_W(16)) uDut4 (
      .clk(clock), .rst_n(rstN4),
      .req_valid(req4Valid), .req_we(req4We), .req_addr(req4Addr), .req_wdata(req4Wdata),
      .rsp_valid(rsp4Valid), .rsp_rdata(rsp4Rdata), .rsp_err(rsp4Err),
      .timer_irq(timer4Irq), .soft_irq(soft4Irq), .mtime_out(mtime4Out)
   );

   // Free-running clock shared by both instances
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one value and report a mismatch
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   function automatic vec_t mkVec(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                                  input logic expErr, input logic [31:0] expRdata);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.expErr = expErr; v.expRdata = expRdata;
      return v;
   endfunction

   task automatic modelReset();
      mTime = 64'd0;
      mCyc  = 0;
      for (int h = 0; h < NH; h++) begin
         mCmp[h]  = 64'hFFFF_FFFF_FFFF_FFFF;
         mMsip[h] = 1'b0;
      end
   endtask

   // Model one bus cycle from the register-map rules: response from the
   // pre-edge state, then the timebase step and any write.
   task automatic modelStep(input logic v, input logic we, input logic [15:0] addr, input logic [31:0] wd,
                            output logic eErr, output logic [31:0] eRd);
      int a, kind, idx;
      logic hiHalf, tick;
      logic [63:0] newTime;
      a = int'({16'b0, addr});
      kind = 0; idx = 0; hiHalf = 1'b0;
      if (a % 4 != 0)                              kind = 0;
      else if (a < 4 * NH)                         begin kind = 1; idx = a / 4; end
      else if (a >= 'h4000 && a < 'h4000 + 8 * NH) begin kind = 2; idx = (a - 'h4000) / 8; hiHalf = (a % 8) == 4; end
      else if (a == 'hBFF8)                        kind = 3;
      else if (a == 'hBFFC)                        kind = 4;
      eErr = v && (kind == 0);
      eRd  = 32'd0;
      if (v && !we) begin
         case (kind)
            1: eRd = {31'b0, mMsip[idx]};
            2: eRd = hiHalf ? mCmp[idx][63:32] : mCmp[idx][31:0];
            3: eRd = mTime[31:0];
            4: eRd = mTime[63:32];
            default: eRd = 32'd0;
         endcase
      end
      tick = (mCyc % P) == (P - 1);
      mCyc++;
      newTime = tick ? mTime + 64'd1 : mTime;
      if (v && we) begin
         case (kind)
            1: mMsip[idx] = wd[0];
            2: if (hiHalf) mCmp[idx][63:32] = wd; else mCmp[idx][31:0] = wd;
            3: newTime = {mTime[63:32], wd};
            4: newTime = {wd, mTime[31:0]};
            default: ;
         endcase
      end
      mTime = newTime;
   endtask

   // Drive one request cycle to the PRESCALE=1 instance and check every output
   task automatic applyStimulus(input logic v, input logic we, input logic [15:0] addr, input logic [31:0] wd);
      logic eErr;
      logic [31:0] eRd;
      logic [1:0] eTimer, eSoft;
      reqValid = v; reqWe = we; reqAddr = addr; reqWdata = wd;
      modelStep(v, we, addr, wd, eErr, eRd);
      @(posedge clock);
      #1;
      for (int h = 0; h < NH; h++) begin
         eTimer[h] = (mTime >= mCmp[h]);
         eSoft[h]  = mMsip[h];
      end
      checkOutput("rsp_valid", 64'(rspValid), 64'(v));
      checkOutput("rsp_err", 64'(rspErr), 64'(eErr));
      checkOutput("rsp_rdata", 64'(rspRdata), 64'(eRd));
      checkOutput("mtime_out", mtimeOut, mTime);
      checkOutput("timer_irq", 64'(timerIrq), 64'(eTimer));
      checkOutput("soft_irq", 64'(softIrq), 64'(eSoft));
      reqValid = 1'b0;
   endtask

   task automatic step4(input logic v, input logic we, input logic [15:0] addr, input logic [31:0] wd);
      req4Valid = v; req4We = we; req4Addr = addr; req4Wdata = wd;
      @(posedge clock);
      #1;
      req4Valid = 1'b0;
   endtask

   initial begin
      logic seen;
      logic [15:0] pool [12];
      logic [15:0] ra;

      vecs[0]  = mkVec(1'b0, 16'h4000, 32'h0,         1'b0, 32'hFFFF_FFFF);
      vecs[1]  = mkVec(1'b0, 16'h4004, 32'h0,         1'b0, 32'hFFFF_FFFF);
      vecs[2]  = mkVec(1'b1, 16'h0004, 32'h1,         1'b0, 32'h0);
      vecs[3]  = mkVec(1'b0, 16'h0004, 32'h0,         1'b0, 32'h1);
      vecs[4]  = mkVec(1'b1, 16'h0004, 32'hFFFF_FFFE, 1'b0, 32'h0);
      vecs[5]  = mkVec(1'b0, 16'h0004, 32'h0,         1'b0, 32'h0);
      vecs[6]  = mkVec(1'b0, 16'h0008, 32'h0,         1'b1, 32'h0);
      vecs[7]  = mkVec(1'b1, 16'h4010, 32'h5,         1'b1, 32'h0);
      vecs[8]  = mkVec(1'b0, 16'h0002, 32'h0,         1'b1, 32'h0);
      vecs[9]  = mkVec(1'b0, 16'h4010, 32'h0,         1'b1, 32'h0);
      vecs[10] = mkVec(1'b0, 16'h1000, 32'h0,         1'b1, 32'h0);
      vecs[11] = mkVec(1'b1, 16'h4008, 32'h1234,      1'b0, 32'h0);
      vecs[12] = mkVec(1'b0, 16'h4008, 32'h0,         1'b0, 32'h1234);
      vecs[13] = mkVec(1'b0, 16'h400C, 32'h0,         1'b0, 32'hFFFF_FFFF);
      vecs[14] = mkVec(1'b1, 16'h4008, 32'hFFFF_FFFF, 1'b0, 32'h0);
      vecs[15] = mkVec(1'b0, 16'h0000, 32'h0,         1'b0, 32'h0);

      rstN = 1'b0; rstN4 = 1'b0;
      reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0;
      req4Valid = 1'b0; req4We = 1'b0; req4Addr = '0; req4Wdata = '0;
      modelReset();

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_rsp_valid", 64'(rspValid), 64'd0);
      checkOutput("reset_rsp_err", 64'(rspErr), 64'd0);
      checkOutput("reset_rsp_rdata", 64'(rspRdata), 64'd0);
      checkOutput("reset_timer_irq", 64'(timerIrq), 64'd0);
      checkOutput("reset_soft_irq", 64'(softIrq), 64'd0);
      checkOutput("reset_mtime", mtimeOut, 64'd0);
      rstN = 1'b1;

      // Directed register-map vectors
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         checkOutput("vec_err", 64'(rspErr), 64'(vecs[i].expErr));
         checkOutput("vec_rdata", 64'(rspRdata), 64'(vecs[i].expRdata));
      end

      // Timer interrupt fires exactly when mtime reaches mtimecmp[0]
      applyStimulus(1'b1, 1'b1, 16'hBFFC, 32'h0);
      applyStimulus(1'b1, 1'b1, 16'hBFF8, 32'h0);
      applyStimulus(1'b1, 1'b1, 16'h4004, 32'h0);
      applyStimulus(1'b1, 1'b1, 16'h4000, 32'd20);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
         if (mtimeOut == 64'd19) checkOutput("irq_before_cmp", 64'(timerIrq), 64'd0);
         if (mtimeOut == 64'd20) begin
            checkOutput("irq_at_cmp", 64'(timerIrq), 64'd1);
            seen = 1'b1;
         end
      end
      checkOutput("cmp_reached", 64'(seen), 64'd1);
      applyStimulus(1'b1, 1'b1, 16'h4000, 32'hFFFF_FFFF);
      checkOutput("irq_dropped", 64'(timerIrq), 64'd0);

      // Carry from the low half and 64-bit wrap
      applyStimulus(1'b1, 1'b1, 16'hBFF8, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 1'b1, 16'hBFFC, 32'h0);
      checkOutput("hi_write_no_carry", mtimeOut, 64'h0000_0000_FFFF_FFFF);
      applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
      checkOutput("carry_into_hi", mtimeOut, 64'h1_0000_0000);
      applyStimulus(1'b1, 1'b1, 16'hBFFC, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 1'b1, 16'hBFF8, 32'hFFFF_FFFF);
      checkOutput("all_ones", mtimeOut, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
      checkOutput("wrap_to_zero", mtimeOut, 64'd0);

      // Software interrupt follows bit0 of msip
      applyStimulus(1'b1, 1'b1, 16'h0004, 32'h1);
      checkOutput("soft_set", 64'(softIrq), 64'd2);
      applyStimulus(1'b1, 1'b0, 16'h0004, 32'h0);
      checkOutput("soft_read", 64'(rspRdata), 64'd1);
      applyStimulus(1'b1, 1'b1, 16'h0004, 32'hFFFF_FFFE);
      checkOutput("soft_clear", 64'(softIrq), 64'd0);

      // Randomised traffic against the model
      pool[0] = 16'h0000; pool[1] = 16'h0004; pool[2] = 16'h0008; pool[3] = 16'h0002;
      pool[4] = 16'h4000; pool[5] = 16'h4004; pool[6] = 16'h4008; pool[7] = 16'h400C;
      pool[8] = 16'h4010; pool[9] = 16'hBFF8; pool[10] = 16'hBFFC; pool[11] = 16'hBFF4;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) ra = 16'($urandom);
         else ra = pool[$urandom_range(0, 11)];
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra,
                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom);
      end

      // PRESCALE=4 instance: tick every 4th clock, write in a tick cycle, async reset
      rstN4 = 1'b1;
      repeat (3) step4(1'b0, 1'b0, 16'h0, 32'h0);
      checkOutput("ps4_before_tick", mtime4Out, 64'd0);
      step4(1'b0, 1'b0, 16'h0, 32'h0);
      checkOutput("ps4_first_tick", mtime4Out, 64'd1);
      repeat (4) step4(1'b0, 1'b0, 16'h0, 32'h0);
      checkOutput("ps4_second_tick", mtime4Out, 64'd2);
      repeat (3) step4(1'b0, 1'b0, 16'h0, 32'h0);
      checkOutput("ps4_hold", mtime4Out, 64'd2);
      step4(1'b1, 1'b1, 16'hBFF8, 32'd100);
      checkOutput("ps4_write_in_tick", mtime4Out, 64'd100);
      repeat (3) step4(1'b0, 1'b0, 16'h0, 32'h0);
      checkOutput("ps4_after_write", mtime4Out, 64'd100);
      step4(1'b0, 1'b0, 16'h0, 32'h0);
      checkOutput("ps4_next_tick", mtime4Out, 64'd101);
      step4(1'b1, 1'b0, 16'hBFF8, 32'h0);
      checkOutput("ps4_rsp_valid", 64'(rsp4Valid), 64'd1);
      checkOutput("ps4_rdata", 64'(rsp4Rdata), 64'd101);
      rstN4 = 1'b0;
      #1;
      checkOutput("ps4_async_mtime", mtime4Out, 64'd0);
      checkOutput("ps4_async_rsp", 64'(rsp4Valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
